lcd_tile_cmd_seq: RTL
=====================

// Module: lcd_tile_cmd_seq
// PURPOSE
//  Parametrised LCD command sequencer with a byte-level valid/ready output stream.
//  Runs the panel init sequence on request, or draws one TILE_W x TILE_H tile at grid (X,Y).
//  A tile draw is CASET, PASET, RAMWR, then the full pixel fill in a 16-bit colour from obj_code.
//  Sits between the game/update controller and the SPI/8080 byte writer.
// PARAMETERS
//  TILE_W     20     tile width in pixels (1..255)
//  TILE_H     20     tile height in pixels (1..255)
//  COORD_W    4      width of grid indices x_in/y_in
//  DELAY_CYC  50000  idle cycles after SWRESET and after SLPOUT
// PORTS
//  clk          in   1        clock
//  nrst         in   1        async active-low reset
//  start        in   1        request pulse; sampled only in IDLE
//  init_req     in   1        with start: 1=init sequence, 0=tile draw
//  x_in         in   COORD_W  tile column, latched on accepted start
//  y_in         in   COORD_W  tile row, latched on accepted start
//  obj_code     in   3        tile object code, latched on accepted start
//  byte_ready   in   1        writer accepts byte this cycle
//  byte_valid   out  1        D/dcx hold a byte to send
//  D            out  8        byte
//  dcx          out  1        0=command, 1=data/parameter
//  busy         out  1        high whenever state != IDLE
//  done         out  1        one-cycle pulse after last byte of a sequence transfers
// BEHAVIOUR
//  - Reset (async, any time incl. mid-sequence): state IDLE; byte_valid=0, D=0, dcx=0, busy=0, done=0.
//    All counters and latched inputs cleared. A partial sequence is abandoned, not resumed.
//  - Handshake: a byte transfers on a cycle where byte_valid && byte_ready.
//    While byte_valid=1, D and dcx stay stable until transfer. byte_valid never drops without transfer.
//    Next byte (if any) is presented the cycle after transfer, so back-to-back transfers are 1 byte/cycle.
//  - Accepting a start:
//    - start in IDLE: latch init_req/x/y/obj; busy=1 next cycle; first byte valid that same next cycle.
//    - start while busy is ignored, never queued.
//  - INIT path: bytes and waits in order:
//    0x01 cmd; WAIT DELAY_CYC; 0x28 cmd; 0x11 cmd; WAIT DELAY_CYC; 0x29 cmd.
//    - Each WAIT starts the cycle after the preceding byte transfers.
//    - byte_valid=0 for exactly DELAY_CYC cycles of WAIT.
//  - TILE path: 16-bit coordinates.
//    - SC=x*TILE_W, EC=SC+TILE_W-1, SP=y*TILE_H, EP=SP+TILE_H-1; arithmetic is 16-bit, overflow wraps.
//    - Byte order: 0x2A cmd, SC[15:8], SC[7:0], EC[15:8], EC[7:0];
//      0x2B cmd, SP hi, SP lo, EP hi, EP lo; 0x2C cmd.
//    - Then TILE_W*TILE_H pixels, each colour[15:8] then colour[7:0], all dcx=1.
//  - Colour table: 0=FFFF, 1=901E, 2=6815, 3=F800, 4=0814, 5..7=FFFF.
//  - Pixel counter: row/col counters; col wraps at TILE_W-1 -> 0 and increments row; sequence ends after row TILE_H-1, col TILE_W-1.
//  - States: IDLE, INIT_CMD, INIT_WAIT, ADDR (11-step byte index), PIX_HI, PIX_LO, FINISH.
//    - FINISH lasts 1 cycle: done=1, busy=1.
//    - Then IDLE. start can be accepted on the first IDLE cycle.
//  - byte_ready may be held high permanently or toggled arbitrarily. Sequence content never depends on ready timing.
// CONFIGURATION
//  TILE_BORDER_EN defined:
//    - pixels with row==0 or col==0 of the tile are sent as 0x0000 (black grid lines).
//    - all other pixels use the colour table. Byte count is unchanged.
//  TILE_BORDER_EN undefined: every pixel uses the colour table.
// TESTING
//  1 reset mid-tile: assert nrst=0 after 5 transfers -> byte_valid=0, busy=0 immediately; new start restarts at 0x2A.
//  2 init, ready=1, DELAY_CYC=10:
//    - bytes 01,28,11,29 all dcx=0;
//    - exactly 10 valid-low cycles after 01 and after 11;
//    - done pulses once.
//  3 tile x=3,y=2,obj=3, ready=1:
//    - header 2A,00,3C,00,4F,2B,00,28,00,3B,2C;
//    - then 800 bytes alternating F8,00;
//    - total 811 transfers, then done.
//  4 back-pressure:
//    - ready toggled pseudo-randomly during tile x=0,y=0,obj=1;
//    - D/dcx stable while valid && !ready;
//    - byte stream identical to ready=1 run.
//  5 start pulsed while busy with x=5 -> ignored; coordinates in stream remain from first request.
//  6 TILE_BORDER_EN, obj=0:
//    - first 20 pixels 0000;
//    - pixel 21 is 0000 (row1 col0);
//    - pixel 22 is FFFF.

Source files
------------

// File: rtl/lcd_tile_cmd_seq.sv
// rtl/lcd_tile_cmd_seq.sv - LCD init/tile-draw command sequencer with byte valid/ready output
//
// Purpose:
//   On an accepted start, the block does one of two jobs:
//   - emit the panel init sequence, or
//   - draw one TILE_W x TILE_H tile at grid (x_in, y_in). A tile draw is CASET,
//     PASET and RAMWR, followed by a solid 16-bit colour fill selected by obj_code.
//   Bytes leave on a valid/ready stream toward the SPI/8080 writer.
//
// Ports:
//   clk, nrst           clock, asynchronous active-low reset
//   start               request pulse, only honoured in IDLE
//   init_req            with start: 1 = init sequence, 0 = tile draw
//   x_in, y_in          tile grid column/row, latched on accepted start
//   obj_code            tile object code, latched on accepted start
//   byte_ready          writer accepts the presented byte this cycle
//   byte_valid, D, dcx  byte stream (dcx 0 = command, 1 = data)
//   busy                high whenever not IDLE
//   done                one-cycle pulse after the last byte of a sequence
//
// Configuration:
//   TILE_BORDER_EN      when defined, pixels in tile row 0 or column 0 are black

`timescale 1ns/1ps

module lcd_tile_cmd_seq #(
  parameter int TILE_W    = 20,
  parameter int TILE_H    = 20,
  parameter int COORD_W   = 4,
  parameter int DELAY_CYC = 50000
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               init_req,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [2:0]         obj_code,
  input  logic               byte_ready,
  output logic               byte_valid,
  output logic [7:0]         D,
  output logic               dcx,
  output logic               busy,
  output logic               done
);

  localparam int DW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT_CMD,
    INIT_WAIT,
    ADDR,
    PIX_HI,
    PIX_LO,
    FINISH
  } state_t;

  state_t             state, next;
  logic [COORD_W-1:0] x_r, y_r;
  logic [2:0]         obj_r;
  logic [3:0]         idx;      // init step (0..3) or address byte index (0..10)
  logic [DW-1:0]      dly_cnt;
  logic [7:0]         row, col;

  logic        xfer;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] colour, pix;
  logic        last_pix;

  assign xfer = byte_valid && byte_ready;

  // Window coordinates, 16-bit with wrap on overflow.
  assign sc = 16'(x_r) * 16'(TILE_W);
  assign ec = sc + 16'(TILE_W - 1);
  assign sp = 16'(y_r) * 16'(TILE_H);
  assign ep = sp + 16'(TILE_H - 1);

  assign last_pix = (row == 8'(TILE_H - 1)) && (col == 8'(TILE_W - 1));

  always_comb begin
    colour = 16'hFFFF;
    case (obj_r)
      3'd1:    colour = 16'h901E;
      3'd2:    colour = 16'h6815;
      3'd3:    colour = 16'hF800;
      3'd4:    colour = 16'h0814;
      default: colour = 16'hFFFF;
    endcase
  end

`ifdef TILE_BORDER_EN
  assign pix = ((row == 8'd0) || (col == 8'd0)) ? 16'h0000 : colour;
`else
  assign pix = colour;
`endif

  // Next state and outputs. D/dcx are decoded from registered state and
  // counters, so they hold steady for as long as a byte waits for ready.
  always_comb begin
    next       = state;
    byte_valid = 1'b0;
    D          = 8'h00;
    dcx        = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next = init_req ? INIT_CMD : ADDR;
      end
      INIT_CMD: begin
        byte_valid = 1'b1;
        case (idx[1:0])
          2'd0:    D = 8'h01;
          2'd1:    D = 8'h28;
          2'd2:    D = 8'h11;
          default: D = 8'h29;
        endcase
        if (xfer) begin
          // SWRESET and SLPOUT are each followed by a settle delay.
          if (idx[1:0] == 2'd0 || idx[1:0] == 2'd2) next = INIT_WAIT;
          else if (idx[1:0] == 2'd3)                next = FINISH;
        end
      end
      INIT_WAIT: begin
        if (dly_cnt == DW'(DELAY_CYC - 1)) next = INIT_CMD;
      end
      ADDR: begin
        byte_valid = 1'b1;
        dcx        = 1'b1;
        case (idx)
          4'd0:    begin D = 8'h2A; dcx = 1'b0; end
          4'd1:    D = sc[15:8];
          4'd2:    D = sc[7:0];
          4'd3:    D = ec[15:8];
          4'd4:    D = ec[7:0];
          4'd5:    begin D = 8'h2B; dcx = 1'b0; end
          4'd6:    D = sp[15:8];
          4'd7:    D = sp[7:0];
          4'd8:    D = ep[15:8];
          4'd9:    D = ep[7:0];
          default: begin D = 8'h2C; dcx = 1'b0; end
        endcase
        if (xfer && idx == 4'd10) next = PIX_HI;
      end
      PIX_HI: begin
        byte_valid = 1'b1;
        dcx        = 1'b1;
        D          = pix[15:8];
        if (xfer) next = PIX_LO;
      end
      PIX_LO: begin
        byte_valid = 1'b1;
        dcx        = 1'b1;
        D          = pix[7:0];
        if (xfer) next = last_pix ? FINISH : PIX_HI;
      end
      FINISH: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      obj_r   <= '0;
      idx     <= '0;
      dly_cnt <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          idx     <= '0;
          dly_cnt <= '0;
          row     <= '0;
          col     <= '0;
          if (start) begin
            x_r   <= x_in;
            y_r   <= y_in;
            obj_r <= obj_code;
          end
        end
        INIT_CMD: begin
          dly_cnt <= '0;
          if (xfer) idx <= idx + 4'd1;
        end
        INIT_WAIT: dly_cnt <= dly_cnt + DW'(1);
        ADDR: begin
          if (xfer) idx <= idx + 4'd1;
        end
        PIX_LO: begin
          if (xfer) begin
            if (col == 8'(TILE_W - 1)) begin
              col <= '0;
              row <= row + 8'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
